// File: rtl/coin_accumulator.sv
// Coin front end of the vending path: edge-detects coin sensors, accumulates the
// deposit, strobes exceed_o for one cycle at vend time, and handles cancel/refund.
module coin_accumulator #(
   parameter int PRICE = 20
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       nickel_i,
   input  logic       dime_i,
   input  logic       quarter_i,
   input  logic       cancel_i,
   output logic [5:0] deposit_o,
   output logic       exceed_o,
   output logic       refund_valid_o,
   output logic [5:0] refund_o,
   output logic       coin_reject_o,
   output logic [7:0] sales_cnt_o
);

   localparam logic [5:0] PRICE_C = 6'(PRICE);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_VEND    = 2'd2
   } state_t;

   // Value of a single coin event; zero unless exactly one sensor rose.
   function automatic logic [5:0] coin_value(input logic [2:0] evt);
      logic [5:0] val;
      val = 6'd0;
      case (evt)
         3'b001:  val = 6'd5;
         3'b010:  val = 6'd10;
         3'b100:  val = 6'd25;
         default: val = 6'd0;
      endcase
      return val;
   endfunction

   function automatic logic more_than_one(input logic [2:0] evt);
      return (evt[0] & evt[1]) | (evt[0] & evt[2]) | (evt[1] & evt[2]);
   endfunction

   state_t     r_state;
   logic [2:0] r_prev;
   logic [5:0] r_deposit;
   logic [5:0] r_refund;
   logic       r_refund_valid;
   logic       r_coin_reject;
   logic [7:0] r_sales_cnt;

   logic [2:0] w_evt;
   logic       w_any;
   logic       w_multi;
   logic       w_legal;
   logic [5:0] w_value;
   logic [5:0] w_sum;

   assign w_evt   = {quarter_i, dime_i, nickel_i} & ~r_prev;
   assign w_any   = |w_evt;
   assign w_multi = more_than_one(w_evt);
   assign w_legal = w_any & ~w_multi;
   assign w_value = coin_value(w_evt);
   // Deposit is zero in IDLE, so one adder covers both IDLE and COLLECT.
   assign w_sum   = r_deposit + w_value;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_prev         <= 3'b111;
         r_state        <= ST_IDLE;
         r_deposit      <= 6'd0;
         r_refund       <= 6'd0;
         r_refund_valid <= 1'b0;
         r_coin_reject  <= 1'b0;
         r_sales_cnt    <= 8'd0;
      end else begin
         r_prev         <= {quarter_i, dime_i, nickel_i};
         r_refund       <= 6'd0;
         r_refund_valid <= 1'b0;
         r_coin_reject  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_coin_reject <= w_multi;
               if (w_legal) begin
                  r_deposit <= w_sum;
                  r_state   <= (w_sum >= PRICE_C) ? ST_VEND : ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               r_coin_reject <= w_multi;
               // Cancel wins over coins; a legal simultaneous coin is refunded too.
               if (cancel_i) begin
                  r_refund_valid <= 1'b1;
                  r_refund       <= w_sum;
                  r_deposit      <= 6'd0;
                  r_state        <= ST_IDLE;
               end else if (w_legal) begin
                  r_deposit <= w_sum;
                  r_state   <= (w_sum >= PRICE_C) ? ST_VEND : ST_COLLECT;
               end
            end
            ST_VEND: begin
               r_coin_reject <= w_any;
               r_deposit     <= 6'd0;
               r_sales_cnt   <= r_sales_cnt + 8'd1;
               r_state       <= ST_IDLE;
            end
            default: begin
               r_deposit <= 6'd0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign deposit_o      = r_deposit;
   assign exceed_o       = (r_state == ST_VEND);
   assign refund_valid_o = r_refund_valid;
   assign refund_o       = r_refund;
   assign coin_reject_o  = r_coin_reject;
   assign sales_cnt_o    = r_sales_cnt;

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed bench for coin_accumulator with PRICE = 20; outputs are sampled on the
// falling edge after each rising edge.
module tb_coin_accumulator;

   logic       clk;
   logic       rst;
   logic       nickel;
   logic       dime;
   logic       quarter;
   logic       cancel;
   logic [5:0] deposit;
   logic       exceed;
   logic       refund_valid;
   logic [5:0] refund;
   logic       coin_reject;
   logic [7:0] sales_cnt;

   int tests = 0;
   int fails = 0;

   coin_accumulator #(.PRICE(20)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .nickel_i       (nickel),
      .dime_i         (dime),
      .quarter_i      (quarter),
      .cancel_i       (cancel),
      .deposit_o      (deposit),
      .exceed_o       (exceed),
      .refund_valid_o (refund_valid),
      .refund_o       (refund),
      .coin_reject_o  (coin_reject),
      .sales_cnt_o    (sales_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; nickel = 1'b0; dime = 1'b0; quarter = 1'b1; cancel = 1'b0;
      step(); step();
      rst = 1'b0;
      step();
      chk("rst_deposit", deposit, 0);
      chk("rst_exceed", exceed, 0);
      chk("rst_refund_valid", refund_valid, 0);
      chk("rst_refund", refund, 0);
      chk("rst_reject", coin_reject, 0);
      chk("rst_sales", sales_cnt, 0);
      step();
      chk("q_held_thru_reset", deposit, 0);
      quarter = 1'b0; step();

      // dime, dime -> vend at 20
      dime = 1'b1; step();
      chk("dime1_dep", deposit, 10);
      chk("dime1_exceed", exceed, 0);
      dime = 1'b0; step();
      dime = 1'b1; step();
      chk("dime2_dep", deposit, 20);
      chk("dime2_exceed", exceed, 1);
      dime = 1'b0; step();
      chk("vend1_dep_after", deposit, 0);
      chk("vend1_exceed_after", exceed, 0);
      chk("vend1_sales", sales_cnt, 1);

      // nickel, dime, quarter -> 40
      nickel = 1'b1; step();
      chk("ov_n_dep", deposit, 5);
      nickel = 1'b0; step();
      dime = 1'b1; step();
      chk("ov_d_dep", deposit, 15);
      dime = 1'b0; step();
      quarter = 1'b1; step();
      chk("ov_q_dep", deposit, 40);
      chk("ov_q_exceed", exceed, 1);
      quarter = 1'b0; step();
      chk("ov_after_dep", deposit, 0);
      chk("ov_sales", sales_cnt, 2);

      // cancel with simultaneous dime
      nickel = 1'b1; step();
      nickel = 1'b0; step();
      cancel = 1'b1; dime = 1'b1; step();
      chk("cxl_refund_valid", refund_valid, 1);
      chk("cxl_refund", refund, 15);
      chk("cxl_dep", deposit, 0);
      chk("cxl_exceed", exceed, 0);
      cancel = 1'b0; dime = 1'b0; step();
      chk("cxl_strobe_end", refund_valid, 0);
      chk("cxl_refund_zero", refund, 0);
      chk("cxl_idle_dep", deposit, 0);

      // cancel with illegal multi-coin: refund deposit only, coin rejected
      nickel = 1'b1; step();
      nickel = 1'b0; step();
      cancel = 1'b1; dime = 1'b1; quarter = 1'b1; step();
      chk("cxlm_refund_valid", refund_valid, 1);
      chk("cxlm_refund", refund, 5);
      chk("cxlm_reject", coin_reject, 1);
      cancel = 1'b0; dime = 1'b0; quarter = 1'b0; step();

      // cancel in IDLE ignored
      cancel = 1'b1; step();
      chk("idle_cxl_ignored", refund_valid, 0);
      cancel = 1'b0; step();

      // illegal simultaneous from IDLE
      nickel = 1'b1; quarter = 1'b1; step();
      chk("multi_reject", coin_reject, 1);
      chk("multi_dep", deposit, 0);
      nickel = 1'b0; quarter = 1'b0; step();
      chk("multi_reject_end", coin_reject, 0);
      chk("multi_dep2", deposit, 0);

      // dime during VEND rejected
      quarter = 1'b1; step();
      chk("vq_dep", deposit, 25);
      chk("vq_exceed", exceed, 1);
      quarter = 1'b0; dime = 1'b1; step();
      chk("vend_dime_reject", coin_reject, 1);
      chk("vend_dime_dep", deposit, 0);
      chk("vend_dime_sales", sales_cnt, 3);
      dime = 1'b0; step();
      chk("vend_dime_dep2", deposit, 0);

      // quarter held 5 cycles mid-COLLECT counted once
      nickel = 1'b1; step();
      nickel = 1'b0; step();
      quarter = 1'b1; step();
      chk("hold_q_dep", deposit, 30);
      chk("hold_q_exceed", exceed, 1);
      step();
      chk("hold_q_dep2", deposit, 0);
      chk("hold_q_sales", sales_cnt, 4);
      chk("hold_q_noreject", coin_reject, 0);
      step(); step(); step();
      chk("hold_q_dep5", deposit, 0);
      chk("hold_q_exceed5", exceed, 0);
      chk("hold_q_sales5", sales_cnt, 4);
      quarter = 1'b0; step();

      // reset during COLLECT at 15
      nickel = 1'b1; step();
      nickel = 1'b0; step();
      dime = 1'b1; step();
      chk("rc_dep15", deposit, 15);
      chk("rc_exceed", exceed, 0);
      dime = 1'b0; rst = 1'b1; step();
      chk("rc_dep0", deposit, 0);
      chk("rc_no_refund", refund_valid, 0);
      chk("rc_sales0", sales_cnt, 0);
      rst = 1'b0; step();
      chk("rc_dep_after", deposit, 0);
      chk("rc_no_refund_after", refund_valid, 0);

      // counter wrap after 256 vends
      for (int i = 0; i < 255; i++) begin
         quarter = 1'b1; step();
         quarter = 1'b0; step();
      end
      chk("wrap_255", sales_cnt, 255);
      quarter = 1'b1; step();
      quarter = 1'b0; step();
      chk("wrap_0", sales_cnt, 0);
      chk("wrap_dep", deposit, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/coin_accumulator.md
# coin_accumulator

Upstream front end of the soda vending path. Edge-detects coin-sensor levels (nickel, dime, quarter) and accumulates the deposit. When the total reaches the price, it presents that total with a one-cycle `exceed_o` strobe, the exact `deposit_i`/`exceed_i` pair the dispensing stage samples. It also handles customer cancel and refund, rejects illegal coin events, and keeps a wrapping sales counter.

## Interface
- `PRICE`, default 20: vend price in cents. Must be a multiple of 5 and satisfy `PRICE - 5 + 25 <= 63`.
- `clk_i  in  1`: single clock; all state changes on the rising edge.
- `rst_i  in  1`: synchronous, active-high reset.
- `nickel_i  in  1`: 5-cent sensor level. A coin event is a 0→1 rise.
- `dime_i  in  1`: 10-cent sensor level. A coin event is a 0→1 rise.
- `quarter_i  in  1`: 25-cent sensor level. A coin event is a 0→1 rise.
- `cancel_i  in  1`: customer cancel request, sampled as a level.
- `deposit_o  out  6`: current accumulated deposit in cents; connects to the dispensing `deposit_i`.
- `exceed_o  out  1`: one-cycle strobe meaning deposit ≥ `PRICE`, vend now; connects to the dispensing `exceed_i`.
- `refund_valid_o  out  1`: one-cycle strobe accompanying a refund.
- `refund_o  out  6`: refund amount in cents. Valid only while `refund_valid_o` is high; 0 otherwise.
- `coin_reject_o  out  1`: one-cycle strobe; the coin event this cycle was returned to the customer, not counted.
- `sales_cnt_o  out  8`: number of completed vends, wrapping.

## Operation
- **Edge detect:** registers `prev[2:0]` hold last-cycle sensor levels. Event = `level & ~prev`. On reset `prev` = 3'b111, so a sensor held high through reset is not counted.
- **Coin value:** nickel 5, dime 10, quarter 25. More than one event in the same cycle is illegal: `coin_reject_o` = 1, nothing is added.
- **FSM:** three states, IDLE / COLLECT / VEND. Reset enters IDLE.
- **IDLE** (deposit 0):
  - A legal event sets `sum` = value. If `sum >= PRICE`, go to VEND; else go to COLLECT.
  - `cancel_i` is ignored.
- **COLLECT** (0 < deposit < `PRICE`):
  - A legal event gives `sum` = deposit + value. If `sum >= PRICE`, go to VEND; else stay in COLLECT.
  - `cancel_i` takes priority over any coin: `refund_o` = deposit + value of a legal simultaneous coin (an illegal multi-coin is rejected, not refunded). `refund_valid_o` = 1, deposit → 0, go to IDLE.
- **VEND:**
  - `exceed_o` = 1 (decoded from the state register) and `deposit_o` holds the vend total (`PRICE`..`PRICE+20`).
  - Any coin event here asserts `coin_reject_o`. `cancel_i` is ignored; the vend wins.
  - Next edge: deposit → 0, `sales_cnt_o` += 1 (255 wraps to 0), go to IDLE.
- **Arithmetic:** 6-bit unsigned. The `PRICE` constraint guarantees no overflow. The change the dispensing stage computes (deposit − `PRICE`) is always in {0,5,10,15,20}.

## Timing
- **Reset values:** `deposit_o` = 0, `exceed_o` = 0, `refund_valid_o` = 0, `refund_o` = 0, `coin_reject_o` = 0, `sales_cnt_o` = 0, state IDLE.
- **Coin latency:** a sensor rise sampled at edge N updates `deposit_o` and state at edge N, visible from cycle N+1.
- **Vend handshake:** `exceed_o` is high for exactly one cycle, with `deposit_o` stable that whole cycle. The dispensing stage samples both at the closing edge, and deposit reads 0 the cycle after.
- **Strobes:** `refund_valid_o`/`refund_o` and `coin_reject_o` are registered and last one cycle.
- **Back-to-back coins:** a sensor must drop for ≥1 cycle before re-rising, otherwise no new event is seen. A continuous high counts once.
- **Reset mid-operation:** `rst_i` in any state discards the deposit with no refund strobe, clears the counter and returns to IDLE.

## Test plan
- **Single-coin path:** reset, then dime, dime → `deposit_o` 10 then 20. The `exceed_o` pulse is 1 cycle with `deposit_o` = 20. Next cycle `deposit_o` = 0 and `sales_cnt_o` = 1.
- **Max overshoot:** nickel, dime, quarter → vend cycle shows `deposit_o` = 40 and `exceed_o` = 1, giving dispensing change 20.
- **Cancel with coin:** nickel, then `cancel_i` together with a dime rise → `refund_valid_o` = 1, `refund_o` = 15, IDLE, `deposit_o` = 0, no `exceed_o`.
- **Illegal simultaneous:** nickel and quarter rising in the same cycle from IDLE → `coin_reject_o` = 1, `deposit_o` stays 0. A dime rise during the VEND cycle → `coin_reject_o` = 1, and the next cycle `deposit_o` is 0, not 10.
- **Reset and level handling:** quarter held high through reset release → no count. Hold quarter high for 5 cycles mid-COLLECT → counted once. `rst_i` during COLLECT at 15 → `deposit_o` 0, no refund strobe.
- **Counter wrap:** 256 vends → `sales_cnt_o` wraps to 0.
